// File: rtl/sram_arb_pkg.sv
// Shared types and constants for sram_bus_arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   // Memory read latency must stay within what the down-counter can hold.
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;
   localparam int CNT_W   = 2;

   function automatic bit lat_legal(input int lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the instruction-fetch and data-access SRAM channels onto one
// synchronous memory port, one outstanding transaction at a time.
// Build option: define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise
// data always wins a tie against instruction fetch.
module sram_bus_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic [3:0]        data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (!lat_legal(LAT)) begin : g_lat_check
      $error("sram_bus_arbiter: LAT must be in 1..4");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             wr_q, wr_d;
   logic             grant_data;

`ifdef SRAM_ARB_RR_EN
   logic             last_q, last_d;

   // On a tie, hand the port to whichever side did not win last time.
   always_comb begin
      grant_data = data_req & (~inst_req | (last_q == OWN_INST));
   end
`else
   // Data wins every tie so the older memory-stage access never waits on fetch.
   always_comb begin
      grant_data = data_req;
   end
`endif

   // Next-state and output decode; every output is forced low while reset is held.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      wr_d         = wr_q;
`ifdef SRAM_ARB_RR_EN
      last_d       = last_q;
`endif
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      mem_en       = 1'b0;
      mem_wen      = '0;
      mem_addr     = '0;
      mem_wdata    = '0;

      if (resetn) begin
         unique case (state_q)
            IDLE: begin
               if (inst_req || data_req) begin
                  owner_d = grant_data ? OWN_DATA : OWN_INST;
                  wr_d    = grant_data & (|data_wen);
`ifdef SRAM_ARB_RR_EN
                  last_d  = grant_data ? OWN_DATA : OWN_INST;
`endif
                  mem_en  = 1'b1;
                  if (grant_data) begin
                     data_addr_ok = 1'b1;
                     mem_wen      = data_wen;
                     mem_addr     = data_addr;
                     mem_wdata    = data_wdata;
                  end else begin
                     inst_addr_ok = 1'b1;
                     mem_addr     = inst_addr;
                  end
                  if (LAT > 1) begin
                     state_d = BUSY;
                     cnt_d   = CNT_W'(LAT - 1);
                  end else begin
                     state_d = RESP;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RESP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (owner_q == OWN_DATA) begin
                  data_data_ok = 1'b1;
                  data_rdata   = wr_q ? '0 : mem_rdata;
               end else begin
                  inst_data_ok = 1'b1;
                  inst_rdata   = mem_rdata;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, latency counter and registered owner; reset drops any in-flight access.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= OWN_DATA;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
      end
   end

`ifdef SRAM_ARB_RR_EN
   // Last-grant register; starting at "inst" makes the first tie go to data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= OWN_INST;
      end else begin
         last_q <= last_d;
      end
   end
`endif

endmodule
